// File: rtl/cdc_tx_serializer.sv
// Write-side feeder for the 2-deep async CDC FIFO: takes one upstream word,
// emits an optional sequence-number header beat, then the word LSB chunk first.
module cdc_tx_serializer #(
   parameter int DATA_WIDTH = 8,
   parameter int WORD_WIDTH = 32,
   parameter int HEADER_EN  = 1
) (
   input  logic                  clkA_i,
   input  logic                  cA_rst_ni,
   input  logic                  cA_valid_i,
   input  logic [WORD_WIDTH-1:0] cA_data_i,
   output logic                  cA_ready_o,
   output logic                  cA_wea_o,
   output logic [DATA_WIDTH-1:0] cA_dina_o,
   input  logic                  cA_wrdy_i,
   output logic                  cA_busy_o,
   output logic [DATA_WIDTH-1:0] cA_seq_o
);

   localparam int BEATS = WORD_WIDTH / DATA_WIDTH;
   localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

   if (WORD_WIDTH % DATA_WIDTH != 0) begin : g_width_chk
      $error("cdc_tx_serializer: WORD_WIDTH must be a multiple of DATA_WIDTH");
   end

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_HDR  = 2'd1,
      S_DATA = 2'd2
   } state_t;

   state_t                r_state, w_state_n;
   logic [WORD_WIDTH-1:0] r_shreg, w_shreg_n, w_shreg_sh;
   logic [CNT_W-1:0]      r_cnt, w_cnt_n;
   logic [DATA_WIDTH-1:0] r_seq, w_seq_n;
   logic [DATA_WIDTH-1:0] r_dina, w_dina_n;
   logic                  r_wea, w_wea_n;
   logic                  w_accept, w_xfer, w_last;

   assign cA_ready_o = (r_state == S_IDLE);
   assign cA_busy_o  = (r_state != S_IDLE);
   assign cA_wea_o   = r_wea;
   assign cA_dina_o  = r_dina;
   assign cA_seq_o   = r_seq;

   assign w_accept   = cA_valid_i & cA_ready_o;
   assign w_xfer     = r_wea & cA_wrdy_i;
   assign w_shreg_sh = r_shreg >> DATA_WIDTH;
   assign w_last     = (r_cnt == CNT_W'(BEATS - 1));

   // Outputs are computed one cycle ahead so wrdy never reaches a port combinationally.
   always_comb begin
      w_state_n = r_state;
      w_shreg_n = r_shreg;
      w_cnt_n   = r_cnt;
      w_seq_n   = r_seq;
      w_dina_n  = r_dina;
      w_wea_n   = r_wea;
      case (r_state)
         S_IDLE: begin
            if (w_accept) begin
               w_shreg_n = cA_data_i;
               w_cnt_n   = '0;
               w_wea_n   = 1'b1;
               if (HEADER_EN != 0) begin
                  w_state_n = S_HDR;
                  w_dina_n  = r_seq;
               end else begin
                  w_state_n = S_DATA;
                  w_dina_n  = cA_data_i[DATA_WIDTH-1:0];
               end
            end
         end
         S_HDR: begin
            if (w_xfer) begin
               w_state_n = S_DATA;
               w_dina_n  = r_shreg[DATA_WIDTH-1:0];
            end
         end
         S_DATA: begin
            if (w_xfer) begin
               w_shreg_n = w_shreg_sh;
               w_cnt_n   = r_cnt + CNT_W'(1);
               if (w_last) begin
                  w_state_n = S_IDLE;
                  w_wea_n   = 1'b0;
                  w_dina_n  = '0;
                  w_seq_n   = r_seq + DATA_WIDTH'(1);
               end else begin
                  w_dina_n  = w_shreg_sh[DATA_WIDTH-1:0];
               end
            end
         end
         default: begin
            w_state_n = S_IDLE;
            w_wea_n   = 1'b0;
            w_dina_n  = '0;
         end
      endcase
   end

   always_ff @(posedge clkA_i or negedge cA_rst_ni) begin
      if (!cA_rst_ni) begin
         r_state <= S_IDLE;
         r_shreg <= '0;
         r_cnt   <= '0;
         r_seq   <= '0;
         r_dina  <= '0;
         r_wea   <= 1'b0;
      end else begin
         r_state <= w_state_n;
         r_shreg <= w_shreg_n;
         r_cnt   <= w_cnt_n;
         r_seq   <= w_seq_n;
         r_dina  <= w_dina_n;
         r_wea   <= w_wea_n;
      end
   end

endmodule
